// File: rtl/dec_nto2n_seq.sv
// Registered N:2^N decoder with a valid/ready command port and four output modes:
// latched one-hot, timed one-hot pulse, thermometer, and timed one-hot scan.
module dec_nto2n_seq #(
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned HOLD_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic [1:0]             mode,
  input  logic [HOLD_W-1:0]      hold,
  output logic [(1<<SEL_W)-1:0]  y,
  output logic                   y_valid,
  output logic                   busy
);

  localparam int unsigned OUT_W = 1 << SEL_W;

  localparam logic [1:0] ModeLatch = 2'b00;
  localparam logic [1:0] ModePulse = 2'b01;
  localparam logic [1:0] ModeTherm = 2'b10;
  localparam logic [1:0] ModeScan  = 2'b11;

  typedef enum logic [1:0] {StIdle, StPulse, StScan} state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SEL_W-1:0]    step_q, step_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]    y_q, y_d;
  logic                y_valid_q, y_valid_d;
  logic                accept;
  logic                clear;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] s);
    return OUT_W'(1) << s;
  endfunction

  function automatic logic [OUT_W-1:0] therm(input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      t[i] = (SEL_W'(i) <= s);
    end
    return t;
  endfunction

  assign accept = in_valid & in_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      hold_q    <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    clear     = 1'b0;

    if (!en) begin
      clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            sel_d     = sel;
            hold_d    = hold;
            step_d    = '0;
            cnt_d     = '0;
            y_valid_d = 1'b1;
            unique case (mode)
              ModeLatch: y_d = onehot(sel);
              ModePulse: begin
                y_d     = onehot(sel);
                state_d = StPulse;
              end
              ModeTherm: y_d = therm(sel);
              ModeScan: begin
                y_d     = onehot('0);
                state_d = StScan;
              end
            endcase
          end
        end
        StPulse: begin
          if (cnt_q == hold_q) begin
            clear = 1'b1;
          end else begin
            cnt_d = cnt_q + HOLD_W'(1);
          end
        end
        StScan: begin
          // Step counter stops at sel_q: the last step ends the sequence
          if (cnt_q == hold_q) begin
            if (step_q == sel_q) begin
              clear = 1'b1;
            end else begin
              step_d = step_q + SEL_W'(1);
              cnt_d  = '0;
              y_d    = onehot(step_q + SEL_W'(1));
            end
          end else begin
            cnt_d = cnt_q + HOLD_W'(1);
          end
        end
        default: clear = 1'b1;
      endcase
    end

    if (clear) begin
      state_d   = StIdle;
      step_d    = '0;
      cnt_d     = '0;
      y_d       = '0;
      y_valid_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    in_ready = en & (state_q == StIdle);
    busy     = (state_q != StIdle);
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_dec_nto2n_seq.sv
// Scoreboard bench for dec_nto2n_seq: stimulus queues expected outputs, a monitor
// pops and compares one entry for every cycle the DUT presents y_valid.
module tb_dec_nto2n_seq;

  typedef struct packed {
    logic [3:0] y;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic [1:0] mode;
  logic [3:0] hold;
  logic [3:0] y;
  logic       y_valid;
  logic       busy;

  logic       en3;
  logic       v3;
  logic       rdy3;
  logic [2:0] s3;
  logic [1:0] m3;
  logic [3:0] h3;
  logic [7:0] y3;
  logic       yv3;
  logic       busy3;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  dec_nto2n_seq #(.SEL_W(2), .HOLD_W(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode     (mode),
    .hold     (hold),
    .y        (y),
    .y_valid  (y_valid),
    .busy     (busy)
  );

  dec_nto2n_seq #(.SEL_W(3), .HOLD_W(4)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en3),
    .in_valid (v3),
    .in_ready (rdy3),
    .sel      (s3),
    .mode     (m3),
    .hold     (h3),
    .y        (y3),
    .y_valid  (yv3),
    .busy     (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: one scoreboard entry per valid output cycle; idle cycles must be quiet
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (y_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual y=%0h required no output", y);
        end else begin
          e = sb_q.pop_front();
          check("y", {28'd0, y}, {28'd0, e.y});
          check("busy", {31'd0, busy}, {31'd0, e.busy});
        end
      end else begin
        check("idle_y", {28'd0, y}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("sb_pending", sb_q.size(), 32'd0);
      end
    end
  end

  // Caller sits at a negedge; returns ncyc negedges later. For SCAN, ey is unused.
  task automatic send(input logic [1:0] s, input logic [1:0] m, input logic [3:0] h,
                      input logic [3:0] ey, input int ncyc);
    exp_t e;
    logic [3:0] one;
    one = 4'b0001;
    sel = s; mode = m; hold = h; in_valid = 1'b1;
    case (m)
      2'b00, 2'b10: begin
        e = '{y: ey, busy: 1'b0};
        repeat (ncyc) sb_q.push_back(e);
      end
      2'b01: begin
        e = '{y: ey, busy: 1'b1};
        repeat (int'(h) + 1) sb_q.push_back(e);
      end
      default: begin
        for (int k = 0; k <= int'(s); k++) begin
          e = '{y: one << k, busy: 1'b1};
          repeat (int'(h) + 1) sb_q.push_back(e);
        end
      end
    endcase
    @(negedge clk);
    in_valid = 1'b0;
    sel = ~s; mode = ~m; hold = ~h;
    repeat (ncyc - 1) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    logic [7:0] one8;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; sel = '0; mode = '0; hold = '0;
    en3 = 1'b1; v3 = 1'b0; s3 = '0; m3 = '0; h3 = '0;
    one8 = 8'h01;

    repeat (2) @(negedge clk);
    check("rst_y", {28'd0, y}, 32'd0);
    check("rst_y_valid", {31'd0, y_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #1 check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // T1: async reset mid-SCAN (sel=3 hold=3 would last 16 cycles)
    sel = 2'd3; mode = 2'b11; hold = 4'd3; in_valid = 1'b1;
    e = '{y: 4'b0001, busy: 1'b1};
    repeat (4) sb_q.push_back(e);
    e = '{y: 4'b0010, busy: 1'b1};
    repeat (4) sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("t1_y", {28'd0, y}, 32'd0);
    check("t1_y_valid", {31'd0, y_valid}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // T2: LATCH sweep
    send(2'd0, 2'b00, 4'd0, 4'b0001, 2);
    send(2'd1, 2'b00, 4'd0, 4'b0010, 2);
    send(2'd2, 2'b00, 4'd0, 4'b0100, 2);
    send(2'd3, 2'b00, 4'd0, 4'b1000, 2);

    // T3: disabled with X inputs, then recover
    en = 1'b0; sel = 'x; mode = 'x; hold = 'x; in_valid = 1'b1;
    #1 check("t3_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("t3_y", {28'd0, y}, 32'd0);
    check("t3_y_known", {31'd0, $isunknown(y)}, 32'd0);
    check("t3_y_valid", {31'd0, y_valid}, 32'd0);
    en = 1'b1;
    send(2'd2, 2'b00, 4'd0, 4'b0100, 2);

    // T4: PULSE sel=3 hold=2 with in_valid held high while busy
    sel = 2'd3; mode = 2'b01; hold = 4'd2; in_valid = 1'b1;
    e = '{y: 4'b1000, busy: 1'b1};
    repeat (3) sb_q.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (i == 0) begin
        sel = 2'd0; mode = 2'b00;
      end
      if (i == 2) in_valid = 1'b0;
    end
    @(negedge clk);
    check("t4_in_ready_after", {31'd0, in_ready}, 32'd1);

    // T5: SCAN sel=2 hold=1 full run, then again with en dropped in the 4th cycle
    send(2'd2, 2'b11, 4'd1, 4'b0000, 7);
    sel = 2'd2; mode = 2'b11; hold = 4'd1; in_valid = 1'b1;
    e = '{y: 4'b0001, busy: 1'b1};
    repeat (2) sb_q.push_back(e);
    e = '{y: 4'b0010, busy: 1'b1};
    repeat (2) sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    #1 check("t5_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Boundaries: full walk, single step, 1-cycle pulse
    send(2'd3, 2'b11, 4'd0, 4'b0000, 5);
    send(2'd0, 2'b11, 4'd0, 4'b0000, 2);
    send(2'd1, 2'b01, 4'd0, 4'b0010, 2);

    // T6: THERM, then LATCH replaces it without a gap
    send(2'd1, 2'b10, 4'd0, 4'b0011, 2);
    send(2'd3, 2'b10, 4'd0, 4'b1111, 2);
    send(2'd0, 2'b00, 4'd0, 4'b0001, 2);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;

    // SEL_W=3 instance
    s3 = 3'd7; m3 = 2'b00; h3 = 4'd0; v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    check("w3_latch7", {24'd0, y3}, 32'h80);
    check("w3_latch_valid", {31'd0, yv3}, 32'd1);
    s3 = 3'd7; m3 = 2'b10; v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    check("w3_therm7", {24'd0, y3}, 32'hff);
    s3 = 3'd7; m3 = 2'b11; h3 = 4'd0; v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    check("w3_scan0", {24'd0, y3}, 32'h01);
    check("w3_scan_busy", {31'd0, busy3}, 32'd1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check("w3_scan_step", {24'd0, y3}, {24'd0, one8 << k});
    end
    @(negedge clk);
    check("w3_scan_end_y", {24'd0, y3}, 32'd0);
    check("w3_scan_end_busy", {31'd0, busy3}, 32'd0);
    check("w3_scan_end_valid", {31'd0, yv3}, 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
